// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer. Allocates ROB ids at dispatch, collects CDB results,
// retires one entry per cycle in program order and raises a flush on a mispredicted branch.
// Entry at index k carries ROB id k+1; id 0 means "no tag".
// Optional feature: define ROB_COMMIT_CNT_EN to add a free-running 32-bit commit counter port.
module reorder_buffer #(
    parameter int unsigned ROB_SIZE     = 16,
    parameter int unsigned ROB_ID_WIDTH = 5,
    parameter int unsigned REG_WIDTH    = 5,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    issue_valid_in,
    input  logic [REG_WIDTH-1:0]    issue_rd_in,
    input  logic [DATA_WIDTH-1:0]   issue_pc_in,
    output logic [ROB_ID_WIDTH-1:0] alloc_rob_id_out,
    output logic                    full_out,
    input  logic                    wb_valid_in,
    input  logic [ROB_ID_WIDTH-1:0] wb_rob_id_in,
    input  logic [DATA_WIDTH-1:0]   wb_value_in,
    input  logic                    wb_mispredict_in,
    input  logic [DATA_WIDTH-1:0]   wb_target_pc_in,
    input  logic [ROB_ID_WIDTH-1:0] q1_rob_id_in,
    input  logic [ROB_ID_WIDTH-1:0] q2_rob_id_in,
    output logic                    q1_ready_out,
    output logic                    q2_ready_out,
    output logic [DATA_WIDTH-1:0]   q1_value_out,
    output logic [DATA_WIDTH-1:0]   q2_value_out,
    output logic                    commit_flag_out,
    output logic [REG_WIDTH-1:0]    rd_to_reg_out,
    output logic [DATA_WIDTH-1:0]   V_to_reg_out,
    output logic [ROB_ID_WIDTH-1:0] Q_to_reg_out,
    output logic                    rollback_flag_out,
    output logic [DATA_WIDTH-1:0]   rollback_pc_out,
`ifdef ROB_COMMIT_CNT_EN
    output logic [31:0]             commit_cnt_out,
`endif
    output logic [DATA_WIDTH-1:0]   dbg_commit_pc_out
);

    localparam int unsigned IDX_W = $clog2(ROB_SIZE);
    localparam logic [ROB_ID_WIDTH-1:0] SIZE_ID = ROB_ID_WIDTH'(ROB_SIZE);
    localparam logic [ROB_ID_WIDTH-1:0] ONE_ID  = ROB_ID_WIDTH'(1);

    logic [ROB_SIZE-1:0]   busy;
    logic [ROB_SIZE-1:0]   ready;
    logic [ROB_SIZE-1:0]   mispredict;
    logic [REG_WIDTH-1:0]  ent_rd     [ROB_SIZE];
    logic [DATA_WIDTH-1:0] ent_value  [ROB_SIZE];
    logic [DATA_WIDTH-1:0] ent_pc     [ROB_SIZE];
    logic [DATA_WIDTH-1:0] ent_target [ROB_SIZE];

    logic [IDX_W-1:0]        head;
    logic [IDX_W-1:0]        tail;
    logic [ROB_ID_WIDTH-1:0] count;

    logic             commit_now;
    logic             rollback_now;
    logic             dispatch;
    logic             wb_hit;
    logic [IDX_W-1:0] wb_idx;
    logic [IDX_W-1:0] q1_idx;
    logic [IDX_W-1:0] q2_idx;

    assign full_out         = (count == SIZE_ID);
    assign alloc_rob_id_out = full_out ? '0 : ROB_ID_WIDTH'(tail) + ONE_ID;

    // Commit only looks at the registered ready bit, so a same-cycle writeback never retires.
    assign commit_now   = rdy_in & busy[head] & ready[head];
    assign rollback_now = commit_now & mispredict[head];

    assign wb_idx   = IDX_W'(wb_rob_id_in - ONE_ID);
    assign wb_hit   = rdy_in & wb_valid_in & (wb_rob_id_in != '0) & (wb_rob_id_in <= SIZE_ID)
                      & busy[wb_idx] & ~rollback_now;
    assign dispatch = rdy_in & issue_valid_in & ~full_out & ~rollback_now;

    assign q1_idx = IDX_W'(q1_rob_id_in - ONE_ID);
    assign q2_idx = IDX_W'(q2_rob_id_in - ONE_ID);

    // Operand query 1: stored value, else bypass from the CDB in the same cycle.
    always_comb begin
        q1_ready_out = 1'b0;
        q1_value_out = '0;
        if (q1_rob_id_in != '0 && q1_rob_id_in <= SIZE_ID && busy[q1_idx]) begin
            if (ready[q1_idx]) begin
                q1_ready_out = 1'b1;
                q1_value_out = ent_value[q1_idx];
            end else if (wb_valid_in && wb_rob_id_in == q1_rob_id_in) begin
                q1_ready_out = 1'b1;
                q1_value_out = wb_value_in;
            end
        end
    end

    // Operand query 2: same lookup as query 1.
    always_comb begin
        q2_ready_out = 1'b0;
        q2_value_out = '0;
        if (q2_rob_id_in != '0 && q2_rob_id_in <= SIZE_ID && busy[q2_idx]) begin
            if (ready[q2_idx]) begin
                q2_ready_out = 1'b1;
                q2_value_out = ent_value[q2_idx];
            end else if (wb_valid_in && wb_rob_id_in == q2_rob_id_in) begin
                q2_ready_out = 1'b1;
                q2_value_out = wb_value_in;
            end
        end
    end

    // Entry array, pointers and registered commit/rollback outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy              <= '0;
            ready             <= '0;
            mispredict        <= '0;
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            commit_flag_out   <= 1'b0;
            rd_to_reg_out     <= '0;
            V_to_reg_out      <= '0;
            Q_to_reg_out      <= '0;
            rollback_flag_out <= 1'b0;
            rollback_pc_out   <= '0;
            dbg_commit_pc_out <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                ent_rd[i]     <= '0;
                ent_value[i]  <= '0;
                ent_pc[i]     <= '0;
                ent_target[i] <= '0;
            end
        end else begin
            commit_flag_out   <= 1'b0;
            rollback_flag_out <= 1'b0;

            if (wb_hit) begin
                ready[wb_idx]      <= 1'b1;
                ent_value[wb_idx]  <= wb_value_in;
                mispredict[wb_idx] <= wb_mispredict_in;
                ent_target[wb_idx] <= wb_target_pc_in;
            end

            if (commit_now) begin
                commit_flag_out   <= 1'b1;
                rd_to_reg_out     <= ent_rd[head];
                V_to_reg_out      <= ent_value[head];
                Q_to_reg_out      <= ROB_ID_WIDTH'(head) + ONE_ID;
                dbg_commit_pc_out <= ent_pc[head];
                busy[head]        <= 1'b0;
                head              <= head + IDX_W'(1);
            end

            // Flush overrides the head advance above; the mispredicted entry still commits.
            if (rollback_now) begin
                rollback_flag_out <= 1'b1;
                rollback_pc_out   <= ent_target[head];
                busy              <= '0;
                ready             <= '0;
                head              <= '0;
                tail              <= '0;
                count             <= '0;
            end else begin
                if (dispatch) begin
                    busy[tail]       <= 1'b1;
                    ready[tail]      <= 1'b0;
                    mispredict[tail] <= 1'b0;
                    ent_rd[tail]     <= issue_rd_in;
                    ent_pc[tail]     <= issue_pc_in;
                    tail             <= tail + IDX_W'(1);
                end
                case ({dispatch, commit_now})
                    2'b10:   count <= count + ONE_ID;
                    2'b01:   count <= count - ONE_ID;
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef ROB_COMMIT_CNT_EN
    // Retirement counter; survives rollbacks and wraps naturally.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            commit_cnt_out <= '0;
        end else if (commit_now) begin
            commit_cnt_out <= commit_cnt_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (default build, 16 entries).
module tb_reorder_buffer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        issue_valid_in;
    logic [4:0]  issue_rd_in;
    logic [31:0] issue_pc_in;
    logic [4:0]  alloc_rob_id_out;
    logic        full_out;
    logic        wb_valid_in;
    logic [4:0]  wb_rob_id_in;
    logic [31:0] wb_value_in;
    logic        wb_mispredict_in;
    logic [31:0] wb_target_pc_in;
    logic [4:0]  q1_rob_id_in, q2_rob_id_in;
    logic        q1_ready_out, q2_ready_out;
    logic [31:0] q1_value_out, q2_value_out;
    logic        commit_flag_out;
    logic [4:0]  rd_to_reg_out;
    logic [31:0] V_to_reg_out;
    logic [4:0]  Q_to_reg_out;
    logic        rollback_flag_out;
    logic [31:0] rollback_pc_out;
    logic [31:0] dbg_commit_pc_out;
`ifdef ROB_COMMIT_CNT_EN
    logic [31:0] commit_cnt_out;
`endif

    int checks = 0;
    int errors = 0;

    reorder_buffer dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .issue_valid_in    (issue_valid_in),
        .issue_rd_in       (issue_rd_in),
        .issue_pc_in       (issue_pc_in),
        .alloc_rob_id_out  (alloc_rob_id_out),
        .full_out          (full_out),
        .wb_valid_in       (wb_valid_in),
        .wb_rob_id_in      (wb_rob_id_in),
        .wb_value_in       (wb_value_in),
        .wb_mispredict_in  (wb_mispredict_in),
        .wb_target_pc_in   (wb_target_pc_in),
        .q1_rob_id_in      (q1_rob_id_in),
        .q2_rob_id_in      (q2_rob_id_in),
        .q1_ready_out      (q1_ready_out),
        .q2_ready_out      (q2_ready_out),
        .q1_value_out      (q1_value_out),
        .q2_value_out      (q2_value_out),
        .commit_flag_out   (commit_flag_out),
        .rd_to_reg_out     (rd_to_reg_out),
        .V_to_reg_out      (V_to_reg_out),
        .Q_to_reg_out      (Q_to_reg_out),
        .rollback_flag_out (rollback_flag_out),
        .rollback_pc_out   (rollback_pc_out),
`ifdef ROB_COMMIT_CNT_EN
        .commit_cnt_out    (commit_cnt_out),
`endif
        .dbg_commit_pc_out (dbg_commit_pc_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the active edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        #1;
        check("rst_commit", 64'(commit_flag_out), 64'd0);
        check("rst_Q", 64'(Q_to_reg_out), 64'd0);
        check("rst_alloc", 64'(alloc_rob_id_out), 64'd1);
        check("rst_full", 64'(full_out), 64'd0);
        step();
        rst_in = 1'b0;
    endtask

    task automatic wb(input logic [4:0] id, input logic [31:0] val, input logic mp,
                      input logic [31:0] tgt);
        wb_valid_in      = 1'b1;
        wb_rob_id_in     = id;
        wb_value_in      = val;
        wb_mispredict_in = mp;
        wb_target_pc_in  = tgt;
    endtask

    initial begin
        rdy_in = 1'b1; issue_valid_in = 1'b0; issue_rd_in = '0; issue_pc_in = '0;
        wb_valid_in = 1'b0; wb_rob_id_in = '0; wb_value_in = '0; wb_mispredict_in = 1'b0;
        wb_target_pc_in = '0; q1_rob_id_in = '0; q2_rob_id_in = '0;
        do_reset();

        // Three dispatches receive ids 1, 2, 3.
        for (int i = 1; i <= 3; i++) begin
            issue_valid_in = 1'b1;
            issue_rd_in    = 5'(i);
            issue_pc_in    = 32'h1000 + 32'(4 * (i - 1));
            #1;
            check("alloc_seq", 64'(alloc_rob_id_out), 64'(i));
            step();
        end
        issue_valid_in = 1'b0;
        q1_rob_id_in = 5'd2; q2_rob_id_in = 5'd0;
        #1;
        check("alloc_after3", 64'(alloc_rob_id_out), 64'd4);
        check("no_commit_unready", 64'(commit_flag_out), 64'd0);
        check("q1_busy_not_ready", 64'(q1_ready_out), 64'd0);
        check("q2_tag0", 64'(q2_ready_out), 64'd0);

        // Out-of-order writeback, in-order retirement.
        wb(5'd2, 32'h22, 1'b0, 32'h0);
        #1;
        check("q1_bypass_id2", 64'({q1_ready_out, q1_value_out}), 64'h1_0000_0022);
        step();
        wb(5'd1, 32'h11, 1'b0, 32'h0);
        check("no_commit_id2_first", 64'(commit_flag_out), 64'd0);
        step();
        wb_valid_in = 1'b0;
        check("no_commit_same_edge", 64'(commit_flag_out), 64'd0);
        step();
        check("c1_flag", 64'(commit_flag_out), 64'd1);
        check("c1_rd_v_q", 64'({rd_to_reg_out, V_to_reg_out, Q_to_reg_out}),
              64'({5'd1, 32'h11, 5'd1}));
        check("c1_pc", 64'(dbg_commit_pc_out), 64'h1000);
        step();
        check("c2_flag", 64'(commit_flag_out), 64'd1);
        check("c2_rd_v_q", 64'({rd_to_reg_out, V_to_reg_out, Q_to_reg_out}),
              64'({5'd2, 32'h22, 5'd2}));
        step();
        check("id3_holds", 64'(commit_flag_out), 64'd0);

        // Stall with a ready head: nothing moves until rdy_in returns.
        wb(5'd3, 32'h33, 1'b0, 32'h0);
        step();
        wb_valid_in = 1'b0;
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_no_commit", 64'(commit_flag_out), 64'd0);
            check("stall_alloc", 64'(alloc_rob_id_out), 64'd4);
        end
        rdy_in = 1'b1;
        step();
        check("resume_commit", 64'({commit_flag_out, Q_to_reg_out, V_to_reg_out}),
              64'({1'b1, 5'd3, 32'h33}));

        // Asynchronous reset while the commit pulse is high.
        rst_in = 1'b1;
        #1;
        check("async_rst_flag", 64'(commit_flag_out), 64'd0);
        check("async_rst_V", 64'(V_to_reg_out), 64'd0);
        step();
        rst_in = 1'b0;

        // Fill all 16 slots; the 17th dispatch is ignored.
        issue_valid_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            issue_rd_in = 5'(i);
            issue_pc_in = 32'h2000 + 32'(i);
            #1;
            check("fill_alloc", 64'(alloc_rob_id_out), 64'(i + 1));
            step();
        end
        check("full_set", 64'({full_out, alloc_rob_id_out}), 64'({1'b1, 5'd0}));
        step();
        issue_valid_in = 1'b0;
        check("full_17th_ignored", 64'(full_out), 64'd1);
        wb(5'd1, 32'h77, 1'b0, 32'h0);
        step();
        wb_valid_in = 1'b0;
        step();
        check("full_commit", 64'({commit_flag_out, Q_to_reg_out, V_to_reg_out}),
              64'({1'b1, 5'd1, 32'h77}));
        check("wrap_alloc", 64'({full_out, alloc_rob_id_out}), 64'({1'b0, 5'd1}));

        // Mispredict at the head flushes everything.
        do_reset();
        issue_valid_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            issue_rd_in = 5'(i + 8);
            step();
        end
        issue_valid_in = 1'b0;
        wb(5'd1, 32'h55, 1'b1, 32'h100);
        step();
        issue_valid_in = 1'b1;
        wb(5'd2, 32'h66, 1'b0, 32'h0);
        step();
        issue_valid_in = 1'b0;
        wb_valid_in = 1'b0;
        q1_rob_id_in = 5'd2;
        #1;
        check("rb_commit", 64'({commit_flag_out, rd_to_reg_out, V_to_reg_out, Q_to_reg_out}),
              64'({1'b1, 5'd9, 32'h55, 5'd1}));
        check("rb_flag_pc", 64'({rollback_flag_out, rollback_pc_out}), 64'({1'b1, 32'h100}));
        check("rb_alloc", 64'({full_out, alloc_rob_id_out}), 64'({1'b0, 5'd1}));
        check("rb_flushed_query", 64'(q1_ready_out), 64'd0);
        step();
        check("rb_pulse_end", 64'({rollback_flag_out, commit_flag_out}), 64'd0);

        // Same-cycle bypass for a busy, not-yet-ready entry.
        issue_valid_in = 1'b1;
        for (int i = 0; i < 5; i++) step();
        issue_valid_in = 1'b0;
        check("alloc_after5", 64'(alloc_rob_id_out), 64'd6);
        q1_rob_id_in = 5'd5; q2_rob_id_in = 5'd4;
        wb(5'd5, 32'hABCD, 1'b0, 32'h0);
        #1;
        check("q1_bypass_id5", 64'({q1_ready_out, q1_value_out}), 64'h1_0000_ABCD);
        check("q2_id4_waiting", 64'({q2_ready_out, q2_value_out}), 64'd0);
        step();
        wb_valid_in = 1'b0;
        #1;
        check("q1_stored_id5", 64'({q1_ready_out, q1_value_out}), 64'h1_0000_ABCD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
